// File: rtl/nx_fifo_rd_stage.sv
// nx_fifo_rd_stage: drains an nx_fifo into a valid/ready stream through a 2-entry skid buffer
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   clear_i            synchronous flush of skid buffer and counters
//   fifo_empty_i       upstream nx_fifo empty
//   fifo_rdata_i       upstream head word, valid when fifo_empty_i=0
//   fifo_ren_o         pop strobe to upstream (never asserted while empty)
//   out_valid_o/out_ready_i/out_data_o  downstream stream
//   pop_count_o        words popped since reset/clear, wraps
//   stall_count_o      saturating valid&&!ready cycle count, only with NX_FIFO_RD_PERF_EN
module nx_fifo_rd_stage #(
    parameter int WIDTH      = 32,
    parameter int COUNT_W    = 16,
    parameter bit DATA_RESET = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               clear_i,
    input  logic               fifo_empty_i,
    input  logic [WIDTH-1:0]   fifo_rdata_i,
    output logic               fifo_ren_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   out_data_o,
`ifdef NX_FIFO_RD_PERF_EN
    output logic [COUNT_W-1:0] stall_count_o,
`endif
    output logic [COUNT_W-1:0] pop_count_o
);
    logic               init_q;
    logic [1:0]         cnt_q, cnt_d;
    logic               head_q, head_d, tail_q, tail_d;
    logic [COUNT_W-1:0] pop_q, pop_d;
    logic [WIDTH-1:0]   mem_q [2];
    logic               pop_out;

    assign out_valid_o = cnt_q != 2'd0;
    assign out_data_o  = out_valid_o ? mem_q[head_q] : '0;
    assign pop_out     = out_valid_o && out_ready_i;
    // init_q holds off the first pop until one edge after reset release
    assign fifo_ren_o  = init_q && !clear_i && !fifo_empty_i && (cnt_q != 2'd2 || pop_out);
    assign pop_count_o = pop_q;

    always_comb begin
        cnt_d  = clear_i ? 2'd0 : cnt_q + 2'(fifo_ren_o) - 2'(pop_out);
        head_d = clear_i ? 1'b0 : head_q ^ pop_out;
        tail_d = clear_i ? 1'b0 : tail_q ^ fifo_ren_o;
        pop_d  = clear_i ? '0 : pop_q + COUNT_W'(fifo_ren_o);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            init_q <= 1'b0;
            cnt_q  <= 2'd0;
            head_q <= 1'b0;
            tail_q <= 1'b0;
            pop_q  <= '0;
        end else begin
            init_q <= 1'b1;
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            pop_q  <= pop_d;
        end
    end

    // Entries outside the occupied range are masked on out_data_o, so reset is optional
    if (DATA_RESET) begin : g_data_rst
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                mem_q[0] <= '0;
                mem_q[1] <= '0;
            end else if (fifo_ren_o) begin
                mem_q[tail_q] <= fifo_rdata_i;
            end
        end
    end else begin : g_data_nrst
        always_ff @(posedge clk_i) begin
            if (fifo_ren_o) mem_q[tail_q] <= fifo_rdata_i;
        end
    end

`ifdef NX_FIFO_RD_PERF_EN
    logic [COUNT_W-1:0] stall_q, stall_d;
    assign stall_count_o = stall_q;
    always_comb begin
        stall_d = clear_i ? '0 :
                  (out_valid_o && !out_ready_i && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) stall_q <= '0;
        else          stall_q <= stall_d;
    end
`endif
endmodule

// File: tb/tb_nx_fifo_rd_stage.sv
// tb_nx_fifo_rd_stage: scoreboard bench for nx_fifo_rd_stage with an upstream FIFO model
module tb_nx_fifo_rd_stage;
    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [W-1:0]  fifo_rdata = '0;
    logic          fifo_ren;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [CW-1:0] pop_count;
`ifdef NX_FIFO_RD_PERF_EN
    logic [CW-1:0] stall_count;
`endif

    nx_fifo_rd_stage #(.WIDTH(W), .COUNT_W(CW), .DATA_RESET(1'b1)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .clear_i      (clear),
        .fifo_empty_i (fifo_empty),
        .fifo_rdata_i (fifo_rdata),
        .fifo_ren_o   (fifo_ren),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
`ifdef NX_FIFO_RD_PERF_EN
        .stall_count_o(stall_count),
`endif
        .pop_count_o  (pop_count)
    );

    always #5 clk = ~clk;

    logic [W-1:0] src[$];
    logic [W-1:0] exp_q[$];
    int vectors = 0;
    int errs = 0;
    int ren_total = 0;
    int hs_total = 0;
    logic last_ren, last_hs;

    // One clock cycle: present upstream head, sample at negedge+1, score, then advance to next negedge
    task automatic cycle();
        logic [W-1:0] e;
        fifo_empty = (src.size() == 0);
        fifo_rdata = fifo_empty ? '0 : src[0];
        #1;
        last_ren = fifo_ren;
        last_hs  = out_valid && out_ready;
        vectors++;
        if (last_ren && fifo_empty) begin
            errs++;
            $display("FAIL ren_on_empty: fifo_ren=%0b while fifo_empty=1", last_ren);
        end
        if (last_hs) begin
            hs_total++;
            vectors++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL scoreboard_extra: got %h, expected no word", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errs++;
                    $display("FAIL scoreboard_data: got %h, expected %h", out_data, e);
                end
            end
        end
        if (clear) exp_q.delete();
        if (last_ren) begin
            ren_total++;
            exp_q.push_back(src.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        src = '{32'hA5A5A5A5, 32'hA5A5A5A5};
        fifo_empty = 1'b0;
        fifo_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        vectors++;
        if (fifo_ren !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || pop_count !== '0) begin
            errs++;
            $display("FAIL reset_state: ren=%b valid=%b data=%h pop=%h, expected 0 0 0 0",
                     fifo_ren, out_valid, out_data, pop_count);
        end
        rst_n = 1'b1;
        cycle();
        vectors++;
        if (last_ren !== 1'b0) begin
            errs++;
            $display("FAIL init_ren_first: got %b, expected 0", last_ren);
        end
        cycle();
        vectors++;
        if (last_ren !== 1'b1) begin
            errs++;
            $display("FAIL init_ren_second: got %b, expected 1", last_ren);
        end
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5) begin
            errs++;
            $display("FAIL init_first_word: valid=%b data=%h, expected 1 a5a5a5a5", out_valid, out_data);
        end
        out_ready = 1'b1;
        run(4);
    endtask

    task automatic test_stream();
        int h0;
        do_clear();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) src.push_back(W'(i));
        cycle();
        h0 = hs_total;
        run(8);
        vectors++;
        if (hs_total - h0 !== 8) begin
            errs++;
            $display("FAIL stream_rate: %0d handshakes in 8 cycles, expected 8", hs_total - h0);
        end
        vectors++;
        if (pop_count !== 4'd8 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL stream_end: pop=%0d valid=%b, expected 8 0", pop_count, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int r0, h0;
        do_clear();
        out_ready = 1'b0;
        for (int i = 'h10; i <= 'h13; i++) src.push_back(W'(i));
        r0 = ren_total;
        run(5);
        vectors++;
        if (ren_total - r0 !== 2 || pop_count !== 4'd2) begin
            errs++;
            $display("FAIL bp_pulls: ren=%0d pop=%0d, expected 2 2", ren_total - r0, pop_count);
        end
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h10) begin
            errs++;
            $display("FAIL bp_hold: valid=%b data=%h, expected 1 00000010", out_valid, out_data);
        end
`ifdef NX_FIFO_RD_PERF_EN
        vectors++;
        if (stall_count !== 4'd4) begin
            errs++;
            $display("FAIL bp_stall: got %0d, expected 4", stall_count);
        end
`endif
        out_ready = 1'b1;
        h0 = hs_total;
        run(4);
        vectors++;
        if (hs_total - h0 !== 4) begin
            errs++;
            $display("FAIL bp_release: %0d handshakes, expected 4", hs_total - h0);
        end
        run(1);
        vectors++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errs++;
            $display("FAIL bp_drained: valid=%b pending=%0d, expected 0 0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_full_rate();
        do_clear();
        out_ready = 1'b0;
        for (int i = 'h30; i <= 'h35; i++) src.push_back(W'(i));
        run(3);
        out_ready = 1'b1;
        cycle();
        vectors++;
        if (last_ren !== 1'b1 || last_hs !== 1'b1) begin
            errs++;
            $display("FAIL full_rate: ren=%b pop=%b, expected 1 1", last_ren, last_hs);
        end
        out_ready = 1'b0;
        cycle();
        vectors++;
        if (last_ren !== 1'b0 || out_data !== 32'h31) begin
            errs++;
            $display("FAIL full_rate_cnt2: ren=%b data=%h, expected 0 00000031", last_ren, out_data);
        end
        out_ready = 1'b1;
        run(6);
    endtask

    task automatic test_clear();
        int h0;
        do_clear();
        out_ready = 1'b0;
        src = '{32'h20, 32'h21, 32'h22, 32'h23};
        run(3);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        vectors++;
        if (last_ren !== 1'b0) begin
            errs++;
            $display("FAIL clear_ren: got %b, expected 0", last_ren);
        end
        vectors++;
        if (out_valid !== 1'b0 || pop_count !== '0) begin
            errs++;
            $display("FAIL clear_state: valid=%b pop=%0d, expected 0 0", out_valid, pop_count);
        end
        out_ready = 1'b1;
        h0 = hs_total;
        run(4);
        vectors++;
        if (hs_total - h0 !== 2 || pop_count !== 4'd2) begin
            errs++;
            $display("FAIL clear_resume: hs=%0d pop=%0d, expected 2 2", hs_total - h0, pop_count);
        end
    endtask

    task automatic test_wrap();
        do_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) src.push_back(W'($urandom));
        run(19);
        vectors++;
        if (pop_count !== 4'd1) begin
            errs++;
            $display("FAIL pop_wrap: got %0d, expected 1", pop_count);
        end
`ifdef NX_FIFO_RD_PERF_EN
        do_clear();
        out_ready = 1'b0;
        src.push_back(32'hBEEF);
        run(22);
        vectors++;
        if (stall_count !== 4'hF) begin
            errs++;
            $display("FAIL stall_sat: got %h, expected f", stall_count);
        end
        out_ready = 1'b1;
        run(2);
`endif
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        src = '{32'h1, 32'h2, 32'h3};
        run(3);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || pop_count !== '0 || fifo_ren !== 1'b0) begin
            errs++;
            $display("FAIL async_reset: valid=%b pop=%0d ren=%b, expected 0 0 0", out_valid, pop_count, fifo_ren);
        end
        src.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        src = '{32'h77};
        run(4);
        vectors++;
        if (pop_count !== 4'd1 || exp_q.size() != 0) begin
            errs++;
            $display("FAIL post_reset: pop=%0d pending=%0d, expected 1 0", pop_count, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_full_rate();
        test_clear();
        test_wrap();
        test_async_reset();
        vectors++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL leftover_words: %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
